mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU).
//  Sits beside the ALU. It takes the same two register operands, runs a radix-2 shift/add
//  or shift/subtract loop, and writes the architectural HI/LO registers.
//  The control unit drives start/op and stalls the pipeline while busy is high.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      synchronous, active-low reset
//  start         in   1      request; sampled only in IDLE
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  Input1        in   WIDTH  rs operand (multiplicand / dividend)
//  Input2        in   WIDTH  rt operand (multiplier / divisor)
//  busy          out  1      high from the accepting edge until the result edge
//  done          out  1      one-cycle pulse; HI/LO are valid in that cycle
//  div_by_zero   out  1      sticky until next accepted start; set by DIV/DIVU with Input2==0
//  hi            out  WIDTH  HI register (product[63:32] / remainder)
//  lo            out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  Reset (reset_n==0 at clk edge): state=IDLE; busy, done, div_by_zero, hi, lo, counter all 0.
//   Reset mid-operation aborts the operation; no partial result reaches hi/lo.
//  FSM states IDLE -> CALC -> FIX -> IDLE:
//   IDLE: start==1 at edge N latches op and operands (absolute values for MULT/DIV),
//    records result signs, clears counter, sets busy, clears div_by_zero, enters CALC.
//    Divide with Input2==0 enters FIX directly (early out).
//   CALC: one iteration per cycle, 32 cycles (counter 0..31), then enters FIX at edge N+32.
//    Multiply: product shift-right with conditional add (65-bit accumulator).
//    Divide: restoring shift-left/subtract (33-bit partial remainder).
//   FIX: applies sign correction, writes hi/lo, pulses done, clears busy, returns to IDLE.
//    Completes at edge N+33 (N+1 for the divide-by-zero early out).
//  Latency: the result is visible, with done=1, exactly 33 cycles after start is accepted.
//  start while busy or in FIX is ignored (no queueing). hi/lo hold their values between operations.
//  Arithmetic:
//   MULT/MULTU give the full 64-bit product {hi,lo}, signed or unsigned.
//   DIV truncates toward zero; remainder takes the dividend's sign.
//   DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
//   Divide by zero: lo=all ones, hi=Input1, div_by_zero=1.
//  done and busy are never high in the same cycle.
// CONFIGURATION
//  MDU_MTHILO_EN defined: adds inputs wr_hi, wr_lo (1 bit each) and wr_data (WIDTH) for MTHI/MTLO.
//   A write takes effect at the edge only in IDLE with start==0.
//   A write asserted while busy, or together with an accepted start, is dropped.
//  MDU_MTHILO_EN undefined: these ports do not exist; hi/lo change only via FSM or reset.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 33 cycles later, hi=0xFFFFFFFE, lo=0x00000001.
//  MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
//  DIVU 5/0 -> done at N+1, div_by_zero=1, lo=0xFFFFFFFF, hi=5.
//   A following MULT clears div_by_zero on acceptance.
//  reset_n low at CALC cycle 10 -> next cycle busy=0, hi=lo=0.
//   A start pulsed mid-CALC in a separate run is ignored; result is unchanged.
//  MDU_MTHILO_EN: wr_hi=1, wr_data=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; same write while busy -> hi unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing MIPS HI/LO (MULT, MULTU, DIV, DIVU).
// Optional MTHI/MTLO write port enabled by defining MDU_MTHILO_EN.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
`ifdef MDU_MTHILO_EN
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_dz;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [2*WIDTH:0]   w_acc_init;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH:0]   w_mul_nxt;
  logic [2*WIDTH:0]   w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    cond_neg = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
    cond_neg2 = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign hi          = r_hi;
  assign lo          = r_lo;

  // Operand conditioning and per-iteration multiply/divide datapath.
  always_comb begin
    w_accept = (r_state == S_IDLE) && start;
    w_dz     = op[1] && (Input2 == {WIDTH{1'b0}});
    w_a_neg  = !op[0] && Input1[WIDTH-1];
    w_b_neg  = !op[0] && Input2[WIDTH-1];
    w_a_abs  = cond_neg(w_a_neg, Input1);
    w_b_abs  = cond_neg(w_b_neg, Input2);
    // Divide-by-zero keeps the raw dividend so HI can return it unmodified.
    if (op[1]) begin
      w_acc_init = {{(WIDTH+1){1'b0}}, (w_dz ? Input1 : w_a_abs)};
    end else begin
      w_acc_init = {{(WIDTH+1){1'b0}}, w_b_abs};
    end
    w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    if (r_acc[0]) begin
      w_mul_nxt = {1'b0, w_add, r_acc[WIDTH-1:1]};
    end else begin
      w_mul_nxt = {1'b0, r_acc[2*WIDTH:1]};
    end
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opb};
    if (!w_diff[WIDTH]) begin
      w_div_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_nxt = {w_shift, r_acc[WIDTH-2:0], 1'b0};
    end
    w_prod = cond_neg2(r_neg_q, r_acc[2*WIDTH-1:0]);
    w_quo  = cond_neg(r_neg_q, r_acc[WIDTH-1:0]);
    w_rem  = cond_neg(r_neg_r, r_acc[2*WIDTH-1:WIDTH]);
  end

  // Next-state logic for the IDLE -> CALC -> FIX sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_dz ? S_FIX : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(WIDTH-1)) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers, status flags and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt         <= {CNT_W{1'b0}};
      r_acc         <= {(2*WIDTH+1){1'b0}};
      r_opb         <= {WIDTH{1'b0}};
      r_is_div      <= 1'b0;
      r_dz          <= 1'b0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_hi          <= {WIDTH{1'b0}};
      r_lo          <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt         <= {CNT_W{1'b0}};
            r_acc         <= w_acc_init;
            r_opb         <= op[1] ? w_b_abs : w_a_abs;
            r_is_div      <= op[1];
            r_dz          <= w_dz;
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
          end else begin
`ifdef MDU_MTHILO_EN
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
`endif
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_dz) begin
            r_hi          <= r_acc[WIDTH-1:0];
            r_lo          <= {WIDTH{1'b1}};
            r_div_by_zero <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
